// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter.
package led_arb_pkg;

  localparam int unsigned LED_W   = 3;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Round-robin search starting just after `last`, wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   last,
                                    input int unsigned        n);
    pick_t       p;
    int unsigned cand;
    p = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = (32'(last) + k) % n;
      if (k <= n && !p.valid && req[cand[IDX_W-1:0]]) begin
        p.valid = 1'b1;
        p.idx   = cand[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Prescaler: one-cycle tick every CDIV clocks; clr restarts the phase.
module tick_div #(
  parameter int unsigned CDIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CDIV > 1) ? $clog2(CDIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CDIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_arb.sv
// Round-robin time-sharing of the 3-bit LED bank between N_REQ requesters.
module led_arb
  import led_arb_pkg::*;
#(
  parameter int unsigned       N_REQ    = 4,
  parameter int unsigned       CDIV     = 1,
  parameter int unsigned       HOLD     = 3,
  parameter int unsigned       GAP      = 1,
  parameter logic [LED_W-1:0]  IDLE_PAT = 3'b000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [LED_W*N_REQ-1:0]   pat,
  output logic [N_REQ-1:0]         gnt,
  output logic [LED_W-1:0]         led,
  output logic                     busy
);

  localparam int unsigned CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_REQ-1:0] req_ext;
  pick_t              pick;
  logic [LED_W-1:0]   pat_sel;
  logic [N_REQ-1:0]   gnt_sel;
  logic               tick;
  logic               clr;

  // Prescaler phase is realigned on every state entry.
  assign clr = (state_d != state_q);

  tick_div #(.CDIV(CDIV)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = req;
    pick    = rr_pick(req_ext, last_q, N_REQ);
    pat_sel = '0;
    gnt_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick.idx == IDX_W'(i)) begin
        pat_sel    = pat[LED_W*i +: LED_W];
        gnt_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        led_d  = IDLE_PAT;
        busy_d = 1'b0;
        if (pick.valid) begin
          state_d = ST_SHOW;
          led_d   = pat_sel;
          gnt_d   = gnt_sel;
          busy_d  = 1'b1;
          last_d  = pick.idx;
          cnt_d   = CNT_W'(HOLD);
        end
      end
      ST_SHOW: begin
        if (tick) begin
          if (cnt_q == CNT_W'(1)) begin
            if (GAP == 0) begin
              state_d = ST_IDLE;
              led_d   = IDLE_PAT;
              busy_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = ST_GAP;
              led_d   = '0;
              cnt_d   = CNT_W'(GAP);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            led_d   = IDLE_PAT;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = IDLE_PAT;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      led_q   <= IDLE_PAT;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_arb.sv
// Bench for led_arb: vector table, round-robin scoreboard, prescaled timing.
module tb_led_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [3:0]  req_a, req_b;
  logic [11:0] pat_a, pat_b;
  logic [3:0]  gnt_a, gnt_b;
  logic [2:0]  led_a, led_b;
  logic        busy_a, busy_b;

  led_arb #(.N_REQ(4), .CDIV(1), .HOLD(3), .GAP(1), .IDLE_PAT(3'b000)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .pat(pat_a),
    .gnt(gnt_a), .led(led_a), .busy(busy_a)
  );

  led_arb #(.N_REQ(4), .CDIV(4), .HOLD(3), .GAP(1), .IDLE_PAT(3'b000)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .pat(pat_b),
    .gnt(gnt_b), .led(led_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] pat;
    logic [3:0]  gnt;
    logic [2:0]  led;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [2:0] led;
  } exp_t;

  // pat3..pat0
  localparam logic [11:0] PA = {3'b111, 3'b101, 3'b010, 3'b011};
  localparam logic [11:0] PB = {3'b111, 3'b101, 3'b010, 3'b110};

  vec_t vt[19];
  exp_t sb[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   cyc, last_cyc, nshow, ngap;
    bit   have_last, done;

    //          rst   req      pat  gnt      led     busy
    vt[0]  = '{1'b1, 4'b1111, PA, 4'b0000, 3'b000, 1'b0};
    vt[1]  = '{1'b1, 4'b1111, PA, 4'b0000, 3'b000, 1'b0};
    vt[2]  = '{1'b0, 4'b1111, PA, 4'b0001, 3'b011, 1'b1};
    vt[3]  = '{1'b1, 4'b1111, PA, 4'b0000, 3'b000, 1'b0};
    vt[4]  = '{1'b0, 4'b0100, PA, 4'b0100, 3'b101, 1'b1};
    vt[5]  = '{1'b0, 4'b0000, PA, 4'b0000, 3'b101, 1'b1};
    vt[6]  = '{1'b0, 4'b0000, PA, 4'b0000, 3'b101, 1'b1};
    vt[7]  = '{1'b0, 4'b0000, PA, 4'b0000, 3'b000, 1'b1};
    vt[8]  = '{1'b0, 4'b0000, PA, 4'b0000, 3'b000, 1'b0};
    vt[9]  = '{1'b0, 4'b0001, PA, 4'b0001, 3'b011, 1'b1};
    vt[10] = '{1'b0, 4'b0010, PB, 4'b0000, 3'b011, 1'b1};
    vt[11] = '{1'b0, 4'b0000, PB, 4'b0000, 3'b011, 1'b1};
    vt[12] = '{1'b0, 4'b0000, PB, 4'b0000, 3'b000, 1'b1};
    vt[13] = '{1'b0, 4'b0000, PB, 4'b0000, 3'b000, 1'b0};
    vt[14] = '{1'b0, 4'b0000, PB, 4'b0000, 3'b000, 1'b0};
    vt[15] = '{1'b0, 4'b0010, PB, 4'b0010, 3'b010, 1'b1};
    vt[16] = '{1'b1, 4'b0011, PB, 4'b0000, 3'b000, 1'b0};
    vt[17] = '{1'b0, 4'b0011, PB, 4'b0001, 3'b110, 1'b1};
    vt[18] = '{1'b0, 4'b0000, PB, 4'b0000, 3'b110, 1'b1};

    rst_a = 1'b1; req_a = '0; pat_a = PA;
    rst_b = 1'b1; req_b = '0; pat_b = PA;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst_a = vt[i].rst;
      req_a = vt[i].req;
      pat_a = vt[i].pat;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_gnt", i),  gnt_a,  vt[i].gnt);
      check($sformatf("vec%0d_led", i),  led_a,  vt[i].led);
      check($sformatf("vec%0d_busy", i), busy_a, vt[i].busy);
    end

    // Round-robin with all four requesters held high
    @(negedge clk);
    rst_a = 1'b1; req_a = '0;
    @(negedge clk);
    rst_a = 1'b0; req_a = 4'b1111; pat_a = PB;
    sb.push_back('{4'b0001, 3'b110});
    sb.push_back('{4'b0010, 3'b010});
    sb.push_back('{4'b0100, 3'b101});
    sb.push_back('{4'b1000, 3'b111});
    sb.push_back('{4'b0001, 3'b110});
    have_last = 1'b0;
    last_cyc  = 0;
    cyc       = 0;
    while (cyc < 60 && sb.size() > 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (gnt_a != 4'b0000) begin
        e = sb.pop_front();
        check("rr_onehot", {31'b0, $onehot(gnt_a)}, 32'd1);
        check("rr_gnt", gnt_a, e.gnt);
        check("rr_led", led_a, e.led);
        if (have_last) check("rr_spacing", cyc - last_cyc, 5);
        else           check("rr_first_latency", cyc, 1);
        have_last = 1'b1;
        last_cyc  = cyc;
      end
    end
    if (sb.size() != 0) check("rr_timeout_pending", sb.size(), 0);
    @(negedge clk);
    req_a = '0;

    // Prescaled instance: CDIV = 4
    @(negedge clk);
    rst_b = 1'b0; req_b = 4'b0001; pat_b = PA;
    @(posedge clk);
    #1;
    check("pre_gnt", gnt_b, 4'b0001);
    check("pre_led", led_b, 3'b011);
    check("pre_busy", busy_b, 1'b1);
    @(negedge clk);
    req_b = '0;
    pat_b = PB;
    nshow = 1;
    done  = 1'b0;
    while (!done && nshow < 100) begin
      @(posedge clk);
      #1;
      if (led_b == 3'b011 && busy_b) nshow++;
      else done = 1'b1;
    end
    check("pre_show_len", nshow, 12);
    ngap = 0;
    done = 1'b0;
    while (!done && ngap < 100) begin
      if (led_b == 3'b000 && busy_b) begin
        ngap++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    check("pre_gap_len", ngap, 4);
    check("pre_idle_busy", busy_b, 1'b0);
    check("pre_idle_gnt", gnt_b, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
